// File: rtl/vga_layer_mixer.sv
// Two-stage VGA layer compositor: OR/priority mixing, active-area blanking,
// sync alignment, frame-synchronous layer enables and per-frame overlap flags.
module vga_layer_mixer #(
  parameter int                          NUM_LAYERS = 4,
  parameter int                          COLOR_BITS = 3,
  parameter int                          H_ACTIVE   = 640,
  parameter int                          V_ACTIVE   = 480,
  parameter logic [3*COLOR_BITS-1:0]     BG_RGB     = '0,
  parameter logic                        SYNC_IDLE  = 1'b1
) (
  input  logic                               i_CLK,
  input  logic                               i_RST,
  input  logic                               i_hSync,
  input  logic                               i_vSync,
  input  logic [9:0]                         i_display_x_pos,
  input  logic [9:0]                         i_display_y_pos,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] i_layer_rgb,
  input  logic [NUM_LAYERS-1:0]              i_layer_en,
  input  logic                               i_mode,
  output logic [COLOR_BITS-1:0]              o_red,
  output logic [COLOR_BITS-1:0]              o_green,
  output logic [COLOR_BITS-1:0]              o_blue,
  output logic                               o_hSync,
  output logic                               o_vSync,
  output logic [NUM_LAYERS-1:0]              o_collision_mask,
  output logic                               o_frame_done
);

  localparam int         PW    = 3*COLOR_BITS;
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  logic                         s1_valid;
  logic                         s1_hsync;
  logic                         s1_vsync;
  logic [9:0]                   s1_x;
  logic [9:0]                   s1_y;
  logic [NUM_LAYERS*PW-1:0]     s1_rgb;
  logic [NUM_LAYERS-1:0]        s1_en;
  logic                         s1_mode;

  logic [NUM_LAYERS-1:0]        enable_shadow;
  logic [NUM_LAYERS-1:0]        collision_acc;

  logic [NUM_LAYERS-1:0]        opaque;
  logic [PW-1:0]                or_rgb;
  logic [PW-1:0]                pri_rgb;
  logic [PW-1:0]                mix_rgb;
  logic                         found;
  logic                         multi;
  logic                         active;
  logic                         frame_end;
  logic                         collide;

  // Stage 1: register inputs. s1_valid masks the cleared pipeline after reset
  // so the first output cycle is blank rather than background colour.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_valid <= 1'b0;
      s1_hsync <= SYNC_IDLE;
      s1_vsync <= SYNC_IDLE;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_rgb   <= '0;
      s1_en    <= '0;
      s1_mode  <= 1'b0;
    end else begin
      s1_valid <= 1'b1;
      s1_hsync <= i_hSync;
      s1_vsync <= i_vSync;
      s1_x     <= i_display_x_pos;
      s1_y     <= i_display_y_pos;
      s1_rgb   <= i_layer_rgb;
      s1_en    <= i_layer_en;
      s1_mode  <= i_mode;
    end
  end

  always_comb begin
    opaque  = '0;
    or_rgb  = '0;
    pri_rgb = '0;
    found   = 1'b0;
    multi   = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      opaque[k] = enable_shadow[k] && (s1_rgb[k*PW +: PW] != '0);
      if (opaque[k]) begin
        or_rgb = or_rgb | s1_rgb[k*PW +: PW];
        if (found) begin
          multi = 1'b1;
        end else begin
          pri_rgb = s1_rgb[k*PW +: PW];
        end
        found = 1'b1;
      end
    end

    active    = (s1_x < H_LIM) && (s1_y < V_LIM);
    frame_end = s1_valid && (s1_x == 10'd0) && (s1_y == V_LIM);
    collide   = s1_valid && active && multi;

    if (!s1_valid || !active) begin
      mix_rgb = '0;
    end else if (!found) begin
      mix_rgb = BG_RGB;
    end else if (s1_mode) begin
      mix_rgb = pri_rgb;
    end else begin
      mix_rgb = or_rgb;
    end
  end

  // Stage 2: outputs, sticky overlap accumulation, frame-boundary hand-off.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_red            <= '0;
      o_green          <= '0;
      o_blue           <= '0;
      o_hSync          <= SYNC_IDLE;
      o_vSync          <= SYNC_IDLE;
      o_collision_mask <= '0;
      o_frame_done     <= 1'b0;
      collision_acc    <= '0;
      enable_shadow    <= '1;
    end else begin
      {o_red, o_green, o_blue} <= mix_rgb;
      o_hSync                  <= s1_hsync;
      o_vSync                  <= s1_vsync;
      o_frame_done             <= frame_end;
      if (frame_end) begin
        o_collision_mask <= collision_acc;
        collision_acc    <= '0;
        enable_shadow    <= s1_en;
      end else if (collide) begin
        collision_acc <= collision_acc | opaque;
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: expected outputs are queued when each
// pixel is driven and compared two cycles later by a scoreboard process.
module tb_vga_layer_mixer;

  logic        clk;
  logic        i_RST;
  logic        i_hSync;
  logic        i_vSync;
  logic [9:0]  i_display_x_pos;
  logic [9:0]  i_display_y_pos;
  logic [35:0] i_layer_rgb;
  logic [3:0]  i_layer_en;
  logic        i_mode;
  logic [2:0]  o_red;
  logic [2:0]  o_green;
  logic [2:0]  o_blue;
  logic        o_hSync;
  logic        o_vSync;
  logic [3:0]  o_collision_mask;
  logic        o_frame_done;

  vga_layer_mixer #(
    .NUM_LAYERS (4),
    .COLOR_BITS (3),
    .H_ACTIVE   (640),
    .V_ACTIVE   (480),
    .BG_RGB     (9'h049),
    .SYNC_IDLE  (1'b1)
  ) dut (
    .i_CLK            (clk),
    .i_RST            (i_RST),
    .i_hSync          (i_hSync),
    .i_vSync          (i_vSync),
    .i_display_x_pos  (i_display_x_pos),
    .i_display_y_pos  (i_display_y_pos),
    .i_layer_rgb      (i_layer_rgb),
    .i_layer_en       (i_layer_en),
    .i_mode           (i_mode),
    .o_red            (o_red),
    .o_green          (o_green),
    .o_blue           (o_blue),
    .o_hSync          (o_hSync),
    .o_vSync          (o_vSync),
    .o_collision_mask (o_collision_mask),
    .o_frame_done     (o_frame_done)
  );

  typedef struct {
    int         due;
    int         id;
    logic [8:0] rgb;
    logic       hs;
    logic       vs;
    logic       fd;
    logic [3:0] mask;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         nstep = 0;
  logic [3:0] en_drv = 4'hF;
  logic [3:0] mask_exp = 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $error("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert ({o_red, o_green, o_blue} === e.rgb) else begin
        errors++;
        $error("FAIL rgb step %0d: got %h want %h", e.id, {o_red, o_green, o_blue}, e.rgb);
      end
      checks++;
      assert (o_hSync === e.hs) else begin
        errors++;
        $error("FAIL hsync step %0d: got %b want %b", e.id, o_hSync, e.hs);
      end
      checks++;
      assert (o_vSync === e.vs) else begin
        errors++;
        $error("FAIL vsync step %0d: got %b want %b", e.id, o_vSync, e.vs);
      end
      checks++;
      assert (o_frame_done === e.fd) else begin
        errors++;
        $error("FAIL frame_done step %0d: got %b want %b", e.id, o_frame_done, e.fd);
      end
      checks++;
      assert (o_collision_mask === e.mask) else begin
        errors++;
        $error("FAIL mask step %0d: got %b want %b", e.id, o_collision_mask, e.mask);
      end
    end
  end

  function automatic logic [35:0] lay(input int k, input logic [8:0] c);
    lay = {27'd0, c} << (9*k);
  endfunction

  // Drive one pixel for one cycle and queue what must appear two cycles later.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic [35:0] rgb,
                      input logic mode, input logic rst, input logic [8:0] exp_rgb,
                      input logic exp_fd);
    exp_t e;
    exp_t p;
    logic hs;
    logic vs;
    hs = nstep[0];
    vs = nstep[2];
    i_display_x_pos = x;
    i_display_y_pos = y;
    i_layer_rgb     = rgb;
    i_layer_en      = en_drv;
    i_mode          = mode;
    i_RST           = rst;
    i_hSync         = hs;
    i_vSync         = vs;
    if (rst) begin
      mask_exp = 4'h0;
      // the pixel one cycle ahead is squashed by the reset at the next edge
      if (sb.size() > 0) begin
        p = sb.pop_back();
        p.rgb = 9'h000; p.hs = 1'b1; p.vs = 1'b1; p.fd = 1'b0; p.mask = 4'h0;
        sb.push_back(p);
      end
    end
    e.due  = cyc + 2;
    e.id   = nstep;
    e.rgb  = rst ? 9'h000 : exp_rgb;
    e.hs   = rst ? 1'b1 : hs;
    e.vs   = rst ? 1'b1 : vs;
    e.fd   = rst ? 1'b0 : exp_fd;
    e.mask = mask_exp;
    sb.push_back(e);
    nstep++;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_end(input logic [3:0] new_mask);
    mask_exp = new_mask;
    step(10'd0, 10'd480, 36'd0, 1'b0, 1'b0, 9'h000, 1'b1);
  endtask

  initial begin
    i_RST = 1'b1; i_hSync = 1'b1; i_vSync = 1'b1;
    i_display_x_pos = '0; i_display_y_pos = '0;
    i_layer_rgb = '0; i_layer_en = 4'hF; i_mode = 1'b0;
    @(posedge clk);
    #1;

    // reset held, then first pixel exactly two cycles after release
    for (int i = 0; i < 3; i++) step(10'd10, 10'd10, lay(0, 9'h1C0), 1'b0, 1'b1, 9'h000, 1'b0);
    step(10'd10, 10'd10, lay(0, 9'h1C0), 1'b0, 1'b0, 9'h1C0, 1'b0);
    step(10'd11, 10'd10, 36'd0,          1'b0, 1'b0, 9'h049, 1'b0);

    // OR versus priority mixing
    step(10'd100, 10'd50, lay(0, 9'h100) | lay(2, 9'h040), 1'b0, 1'b0, 9'h140, 1'b0);
    step(10'd101, 10'd50, lay(0, 9'h100) | lay(2, 9'h040), 1'b1, 1'b0, 9'h100, 1'b0);
    step(10'd102, 10'd50, lay(2, 9'h040),                  1'b1, 1'b0, 9'h040, 1'b0);
    step(10'd103, 10'd50, lay(2, 9'h040),                  1'b0, 1'b0, 9'h040, 1'b0);
    step(10'd104, 10'd50, lay(0, 9'h020) | lay(1, 9'h018) | lay(3, 9'h005), 1'b0, 1'b0, 9'h03D, 1'b0);
    step(10'd105, 10'd50, lay(0, 9'h020) | lay(1, 9'h018) | lay(3, 9'h005), 1'b1, 1'b0, 9'h020, 1'b0);

    // background and active-area boundaries
    step(10'd200,  10'd100,  36'd0, 1'b0, 1'b0, 9'h049, 1'b0);
    step(10'd201,  10'd100,  36'd0, 1'b1, 1'b0, 9'h049, 1'b0);
    step(10'd700,  10'd100,  lay(0, 9'h1FF) | lay(1, 9'h1FF), 1'b0, 1'b0, 9'h000, 1'b0);
    step(10'd5,    10'd480,  lay(0, 9'h1FF), 1'b0, 1'b0, 9'h000, 1'b0);
    step(10'd1023, 10'd1023, lay(1, 9'h1FF) | lay(2, 9'h1FF), 1'b1, 1'b0, 9'h000, 1'b0);
    step(10'd639,  10'd479,  lay(1, 9'h007), 1'b0, 1'b0, 9'h007, 1'b0);
    step(10'd640,  10'd0,    lay(1, 9'h007), 1'b0, 1'b0, 9'h000, 1'b0);
    step(10'd0,    10'd479,  36'd0,          1'b0, 1'b0, 9'h049, 1'b0);
    frame_end(4'b1111);

    // frame F: layers 1 and 3 overlap for four pixels
    for (int i = 0; i < 4; i++)
      step(10'(300 + i), 10'd200, lay(1, 9'h1C0) | lay(3, 9'h007), (i >= 2), 1'b0,
           (i >= 2) ? 9'h1C0 : 9'h1C7, 1'b0);
    step(10'd310, 10'd200, lay(2, 9'h1FF), 1'b0, 1'b0, 9'h1FF, 1'b0);
    frame_end(4'b1010);
    step(10'd1, 10'd480, 36'd0, 1'b0, 1'b0, 9'h000, 1'b0);

    // frame F+1: no overlap
    step(10'd300, 10'd200, lay(1, 9'h1C0), 1'b0, 1'b0, 9'h1C0, 1'b0);
    step(10'd301, 10'd200, lay(3, 9'h007), 1'b1, 1'b0, 9'h007, 1'b0);
    frame_end(4'b0000);

    // enable change mid-frame takes effect only after the frame end
    step(10'd320, 10'd239, lay(0, 9'h038), 1'b0, 1'b0, 9'h038, 1'b0);
    en_drv = 4'b1110;
    step(10'd320, 10'd240, lay(0, 9'h038),                  1'b0, 1'b0, 9'h038, 1'b0);
    step(10'd321, 10'd240, lay(0, 9'h038) | lay(1, 9'h001), 1'b1, 1'b0, 9'h038, 1'b0);
    step(10'd400, 10'd400, lay(0, 9'h038),                  1'b0, 1'b0, 9'h038, 1'b0);
    frame_end(4'b0011);
    step(10'd0, 10'd0, lay(0, 9'h038),                  1'b0, 1'b0, 9'h049, 1'b0);
    step(10'd1, 10'd0, lay(0, 9'h038) | lay(1, 9'h001), 1'b0, 1'b0, 9'h001, 1'b0);
    en_drv = 4'hF;
    step(10'd2, 10'd0, lay(0, 9'h038), 1'b1, 1'b0, 9'h049, 1'b0);
    frame_end(4'b0000);
    step(10'd3, 10'd0, lay(0, 9'h038), 1'b1, 1'b0, 9'h038, 1'b0);

    // reset mid-frame discards pending overlaps
    step(10'd50,  10'd50,  lay(2, 9'h007) | lay(3, 9'h038), 1'b0, 1'b0, 9'h03F, 1'b0);
    step(10'd60,  10'd50,  36'd0, 1'b0, 1'b0, 9'h049, 1'b0);
    step(10'd100, 10'd100, lay(2, 9'h007) | lay(3, 9'h038), 1'b0, 1'b1, 9'h000, 1'b0);
    step(10'd110, 10'd100, lay(0, 9'h100) | lay(1, 9'h080), 1'b1, 1'b0, 9'h100, 1'b0);
    step(10'd111, 10'd100, lay(0, 9'h100) | lay(1, 9'h080), 1'b0, 1'b0, 9'h180, 1'b0);
    frame_end(4'b0011);
    step(10'd0, 10'd0, 36'd0, 1'b0, 1'b0, 9'h049, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised compositor merging NUM_LAYERS per-pixel RGB sources (paddles, ball, centre line, future score/sprite layers) into one VGA pixel stream.
- Sits between the layer renderers and the VGA pins. Replaces ad-hoc OR-ing in the top level with selectable OR/priority mixing, active-area blanking and background colour.
- Adds sync alignment, frame-synchronous layer enables and per-frame layer-overlap (collision) flags for the game engine.

Parameters:
- NUM_LAYERS, 4: number of input layers (1..8); layer 0 is highest priority.
- COLOR_BITS, 3: bits per colour channel.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- BG_RGB, 0: background colour {R,G,B}, 3*COLOR_BITS wide.
- SYNC_IDLE, 1: sync output level driven during reset (inactive level).

Ports:
- i_CLK  in  1  pixel clock
- i_RST  in  1  synchronous reset, active-high
- i_hSync  in  1  horizontal sync from sync generator
- i_vSync  in  1  vertical sync from sync generator
- i_display_x_pos  in  10  current pixel column
- i_display_y_pos  in  10  current pixel row
- i_layer_rgb  in  NUM_LAYERS*3*COLOR_BITS  packed {R,G,B} per layer; layer k at bits [(k+1)*3*COLOR_BITS-1 : k*3*COLOR_BITS]
- i_layer_en  in  NUM_LAYERS  requested layer enables, applied at frame boundary
- i_mode  in  1  0 = OR mix, 1 = priority mix
- o_red / o_green / o_blue  out  COLOR_BITS each  mixed pixel
- o_hSync / o_vSync  out  1  syncs delayed to match pixel latency
- o_collision_mask  out  NUM_LAYERS  bit k = layer k overlapped another layer during the last completed frame
- o_frame_done  out  1  one-cycle pulse when o_collision_mask updates

Behaviour:
- Clock and reset: one clock, i_CLK. Reset is synchronous and active-high on i_RST.
- Reset values:
  - o_red, o_green, o_blue = 0.
  - o_hSync = o_vSync = SYNC_IDLE.
  - o_collision_mask = 0; o_frame_done = 0.
  - Internal collision accumulator = 0; enable shadow = all ones; pipeline registers cleared.
- Reset mid-frame discards the partial accumulator. Mixing resumes on the first post-reset pixel; the first frame_done follows the next frame-end event.
- Pipeline, fixed latency 2 cycles:
  - Stage 1 registers the inputs. i_mode is sampled per pixel.
  - Stage 2 mixes, blanks and accumulates, and registers the outputs.
  - hSync and vSync pass through the same 2 stages, so input cycle N appears at the outputs in cycle N+2.
- Opaque: layer k is opaque when enable_shadow[k]=1 and its RGB is nonzero.
- Active area: x < H_ACTIVE and y < V_ACTIVE. Outside it, RGB output = 0, and neither BG_RGB nor layers are shown.
- OR mode: output = bitwise OR of the RGB of all opaque layers. No opaque layer gives BG_RGB.
- Priority mode: output = RGB of the lowest-index opaque layer. No opaque layer gives BG_RGB.
- Collision:
  - In the active area, if 2 or more layers are opaque, set the accumulator bit of every opaque layer (sticky).
  - Collision detection does not depend on i_mode.
- Frame-end event: input cycle with x == 0 and y == V_ACTIVE, delayed 2 cycles with the pipeline. In the stage-2 cycle carrying the event:
  - o_collision_mask <= accumulator.
  - accumulator <= 0.
  - o_frame_done <= 1 for exactly that cycle.
  - enable_shadow <= i_layer_en as sampled in stage 1.
- Enable changes mid-frame have no visible effect until after the next frame-end event. This guarantees no tearing.
- Width rule: all comparisons use 10-bit unsigned positions. Positions up to 1023 are legal and simply fall outside the active area.
- NUM_LAYERS = 1: collisions are impossible and the mask stays 0. o_frame_done still pulses each frame.

Test Plan:
- Reset, then 3 idle cycles -> RGB 0, syncs = 1, mask 0, frame_done 0. After release, a layer-0 pixel of 3'b111 red at (10,10) appears on o_red exactly 2 cycles later. hSync toggles with the same 2-cycle skew.
- OR mode, layer0 R=4 and layer2 R=1 on the same pixel -> o_red=5. Priority mode, same stimulus -> o_red=4. Layer0 off (zero) -> o_red=1.
- No opaque layers, BG_RGB=9'h049 -> active pixel outputs R=1,G=1,B=1. Pixel at x=700 -> 0.
- Layer1 and layer3 overlap at (300,200) for 4 pixels in frame F -> at frame end, o_collision_mask=4'b1010 with a single o_frame_done pulse. Frame F+1 without overlap -> mask returns to 0000.
- Deassert i_layer_en[0] at (320,240) -> layer 0 stays visible for the rest of the frame. Layer 0 is absent from the first pixel of the next frame.
- Assert i_RST for 1 cycle at (100,100) with an overlap pending -> accumulator is lost and the next frame_done reports only post-reset overlaps.
